// File: rtl/seg7_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_if
//  Write bus between the pattern generators and the 7-segment scan driver.
//  A transfer happens on a rising clock edge when iWR_EN and oWR_RDY are both
//  high. The producer holds iWR_EN/iWR_IDX/iWR_DATA steady while oWR_RDY is low.
//  Signals:
//   iWR_EN    write request
//   iWR_IDX   target digit 0..2 (3 = accepted and dropped)
//   iWR_DATA  segment pattern (or hex digit + dot when decoding is built in)
//   oWR_RDY   driver can accept a write this cycle
//  Modports: master = pattern logic, slave = scan driver.
// -----------------------------------------------------------------------------
interface seg7_scan_driver_if;
  logic       iWR_EN;
  logic [1:0] iWR_IDX;
  logic [7:0] iWR_DATA;
  logic       oWR_RDY;

  modport master (output iWR_EN, iWR_IDX, iWR_DATA, input oWR_RDY);
  modport slave  (input iWR_EN, iWR_IDX, iWR_DATA, output oWR_RDY);
endinterface

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//  Time-multiplexed driver for a 3-digit 7-segment display. Pattern writes go
//  into a shadow buffer; the whole shadow set is copied into the displayed
//  (active) set in one cycle when the scan wraps from digit 2 to digit 0, so a
//  frame never mixes old and new patterns. Each digit slot starts with a
//  blanking gap (all digits off) to suppress ghosting.
//  Parameters:
//   SCAN_DIV   clocks per digit slot, >= BLANK_CYC+2
//   BLANK_CYC  blanked clocks at the start of each slot, >= 1
//  Ports:
//   iCLK   system clock
//   iRST   asynchronous active-high reset
//   wrBus  write bus (slave side): iWR_EN, iWR_IDX, iWR_DATA, oWR_RDY
//   seg    segment lines, registered
//   baza   digit select, active-low, registered (3'b110 = digit 0)
//  Build option:
//   SEG7_HEX_DECODE_EN  when defined, iWR_DATA[3:0] is decoded to a gfedcba
//                       pattern and iWR_DATA[7] drives the dot; otherwise the
//                       data is stored verbatim.
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int SCAN_DIV  = 12000,
  parameter int BLANK_CYC = 64
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  seg7_scan_driver_if.slave    wrBus,
  output logic [7:0]           seg,
  output logic [2:0]           baza
);

  localparam int            CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST_CNT  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC - 1);

  typedef enum logic {BLANK, DRIVE} scanState_t;

  scanState_t    state;
  logic [CW-1:0] slotCnt;
  logic [1:0]    ptr;
  logic          dirty;
  logic [7:0]    shadowPat [3];
  logic [7:0]    activePat [3];

  logic       slotEnd;
  logic       commit;
  logic       wrFire;
  logic [7:0] wrPat;
  logic [7:0] curPat;

  assign slotEnd = (slotCnt == LAST_CNT);
  // Commit only on the 2->0 wrap with pending writes; writes stall for that
  // single cycle so the shadow copy and a new write never race.
  assign commit  = slotEnd && (ptr == 2'd2) && dirty;
  assign wrBus.oWR_RDY = ~commit;
  assign wrFire  = wrBus.iWR_EN && wrBus.oWR_RDY;

`ifdef SEG7_HEX_DECODE_EN
  logic [6:0] hexSeg;

  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here via the
    // case default) so no latch is inferred.
    unique case (wrBus.iWR_DATA[3:0])
      4'h0:    hexSeg = 7'h3F;
      4'h1:    hexSeg = 7'h06;
      4'h2:    hexSeg = 7'h5B;
      4'h3:    hexSeg = 7'h4F;
      4'h4:    hexSeg = 7'h66;
      4'h5:    hexSeg = 7'h6D;
      4'h6:    hexSeg = 7'h7D;
      4'h7:    hexSeg = 7'h07;
      4'h8:    hexSeg = 7'h7F;
      4'h9:    hexSeg = 7'h6F;
      4'hA:    hexSeg = 7'h77;
      4'hB:    hexSeg = 7'h7C;
      4'hC:    hexSeg = 7'h39;
      4'hD:    hexSeg = 7'h5E;
      4'hE:    hexSeg = 7'h79;
      default: hexSeg = 7'h71;
    endcase
  end

  assign wrPat = {wrBus.iWR_DATA[7], hexSeg};
`else
  assign wrPat = wrBus.iWR_DATA;
`endif

  always_comb begin
    unique case (ptr)
      2'd0:    curPat = activePat[0];
      2'd1:    curPat = activePat[1];
      2'd2:    curPat = activePat[2];
      default: curPat = 8'h00;
    endcase
  end

  // Scan FSM. state always describes the current slotCnt value; seg/baza are
  // registered from it, so the pins lag the counter by exactly one cycle and
  // each slot shows BLANK_CYC blank cycles followed by SCAN_DIV-BLANK_CYC drive.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state   <= BLANK;
      slotCnt <= '0;
      ptr     <= 2'd0;
      dirty   <= 1'b0;
      seg     <= 8'h00;
      baza    <= 3'b111;
      // NOTE: the pattern buffers are small and must start dark, so they are
      // reset explicitly rather than left as uninitialised storage.
      for (int i = 0; i < 3; i++) begin
        shadowPat[i] <= 8'h00;
        activePat[i] <= 8'h00;
      end
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side
      // sees the pre-edge value regardless of statement order.
      if (state == DRIVE) begin
        seg  <= curPat;
        baza <= ~(3'b001 << ptr);
      end else begin
        seg  <= 8'h00;
        baza <= 3'b111;
      end

      if (slotEnd) begin
        slotCnt <= '0;
        ptr     <= (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
        state   <= BLANK;
      end else begin
        slotCnt <= slotCnt + 1'b1;
        if (slotCnt == BLANK_END) state <= DRIVE;
      end

      if (commit) begin
        for (int i = 0; i < 3; i++) activePat[i] <= shadowPat[i];
        dirty <= 1'b0;
      end else if (wrFire && (wrBus.iWR_IDX != 2'd3)) begin
        shadowPat[wrBus.iWR_IDX] <= wrPat;
        dirty                    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//  Directed bench for seg7_scan_driver with SCAN_DIV=8, BLANK_CYC=2 (frame of
//  24 cycles). n counts rising edges since reset release; after edge n the
//  pins show the slot position (n-1) of the frame. Expected patterns are kept
//  in expActive/expShadow and advanced at the frame wrap the bench predicts.
//  Honours SEG7_HEX_DECODE_EN for the expected stored pattern.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = 3 * SCAN_DIV;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic [7:0] seg;
  logic [2:0] baza;

  seg7_scan_driver_if wrBus ();

  seg7_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .wrBus (wrBus),
    .seg   (seg),
    .baza  (baza)
  );

  always #5 iCLK = ~iCLK;

  int         testCnt = 0;
  int         failCnt = 0;
  int         n       = 0;
  logic [7:0] expActive [3];
  logic [7:0] expShadow [3];
  logic       expDirty;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  function automatic logic [7:0] enc(input logic [7:0] d);
`ifdef SEG7_HEX_DECODE_EN
    logic [6:0] p;
    case (d[3:0])
      4'h0: p = 7'h3F; 4'h1: p = 7'h06; 4'h2: p = 7'h5B; 4'h3: p = 7'h4F;
      4'h4: p = 7'h66; 4'h5: p = 7'h6D; 4'h6: p = 7'h7D; 4'h7: p = 7'h07;
      4'h8: p = 7'h7F; 4'h9: p = 7'h6F; 4'hA: p = 7'h77; 4'hB: p = 7'h7C;
      4'hC: p = 7'h39; 4'hD: p = 7'h5E; 4'hE: p = 7'h79; default: p = 7'h71;
    endcase
    return {d[7], p};
`else
    return d;
`endif
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 3; i++) begin
      expActive[i] = 8'h00;
      expShadow[i] = 8'h00;
    end
    expDirty = 1'b0;
  endtask

  // One clock: advance, predict pins for edge n, then sample on the falling edge.
  task automatic cycle();
    int         c;
    int         s;
    logic [2:0] eBaza;
    logic [7:0] eSeg;
    @(posedge iCLK);
    n++;
    c = (n - 1) % SCAN_DIV;
    s = ((n - 1) / SCAN_DIV) % 3;
    eBaza = (c < BLANK_CYC) ? 3'b111 : ~(3'b001 << s);
    eSeg  = (c < BLANK_CYC) ? 8'h00 : expActive[s];
    if ((n % FRAME == 0) && expDirty) begin
      for (int i = 0; i < 3; i++) expActive[i] = expShadow[i];
      expDirty = 1'b0;
    end
    @(negedge iCLK);
    check("baza", 32'(baza), 32'(eBaza));
    check("seg", 32'(seg), 32'(eSeg));
    check("rdy", 32'(wrBus.oWR_RDY), 32'(!((n % FRAME == FRAME - 1) && expDirty)));
  endtask

  task automatic runCycles(input int k);
    for (int i = 0; i < k; i++) cycle();
  endtask

  task automatic runTo(input int pos);
    int guard = 0;
    while ((n % FRAME != pos) && guard < 2 * FRAME) begin
      cycle();
      guard++;
    end
  endtask

  // Called on a falling edge; holds the request until accepted (bounded).
  task automatic wr(input logic [1:0] idx, input logic [7:0] data);
    int guard = 0;
    wrBus.iWR_EN   = 1'b1;
    wrBus.iWR_IDX  = idx;
    wrBus.iWR_DATA = data;
    while (!wrBus.oWR_RDY && guard < 4) begin
      cycle();
      guard++;
    end
    if (guard >= 4) check("wr_accept_timeout", 32'(wrBus.oWR_RDY), 32'd1);
    cycle();
    wrBus.iWR_EN = 1'b0;
    if (idx != 2'd3) begin
      expShadow[idx] = enc(data);
      expDirty = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    wrBus.iWR_EN   = 1'b0;
    wrBus.iWR_IDX  = 2'd0;
    wrBus.iWR_DATA = 8'h00;
    clearModel();

    // Reset values
    repeat (3) @(negedge iCLK);
    iRST = 1'b0;
    n = 0;
    check("rst_seg", 32'(seg), 32'h00);
    check("rst_baza", 32'(baza), 32'(3'b111));
    check("rst_rdy", 32'(wrBus.oWR_RDY), 32'd1);

    // Plain scan order with nothing written (covers one full frame + wrap)
    runCycles(30);

    // Commit: writes mid-frame appear only from the next frame
    runTo(3);
    wr(2'd0, 8'h39);
    wr(2'd2, 8'hC5);
    runCycles(2 * FRAME);

    // Dropped write to index 3: accepted, no shadow change, no commit
    runTo(10);
    check("idx3_rdy", 32'(wrBus.oWR_RDY), 32'd1);
    wr(2'd3, 8'hFF);
    runCycles(FRAME);

    // Collision: pending digit1 write, second write held on the wrap cycle
    runTo(4);
    wr(2'd1, 8'h11);
    runTo(FRAME - 1);
    wrBus.iWR_EN   = 1'b1;
    wrBus.iWR_IDX  = 2'd1;
    wrBus.iWR_DATA = 8'h88;
    check("collide_rdy_low", 32'(wrBus.oWR_RDY), 32'd0);
    wr(2'd1, 8'h88);
    runCycles(3 * FRAME);

    // Reset asserted mid-drive of digit 0 (showing a nonzero pattern)
    runTo(5);
    #2 iRST = 1'b1;
    #1;
    check("midrst_seg", 32'(seg), 32'h00);
    check("midrst_baza", 32'(baza), 32'(3'b111));
    check("midrst_rdy", 32'(wrBus.oWR_RDY), 32'd1);
    @(negedge iCLK);
    @(negedge iCLK);
    iRST = 1'b0;
    n = 0;
    clearModel();
    runCycles(FRAME + 4);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
